// File: rtl/nibble_serial_subtractor_pkg.sv
// nibble_serial_subtractor_pkg: shared FSM states, nibble width and step-count helper
package subtractor_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int NIBBLE = 4;
  function automatic int nibble_count(input int width);
    return width / NIBBLE;
  endfunction
endpackage

// File: rtl/nibble_serial_subtractor_if.sv
// nibble_serial_subtractor_if: operand/result valid-ready bundle for the serial subtractor
interface nibble_serial_subtractor_if #(parameter int WIDTH = 8);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic bin;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] diff;
  logic bout;
  logic ovf;
  logic zero;
  modport master (
    output in_valid, a, b, bin, out_ready,
    input in_ready, out_valid, diff, bout, ovf, zero
  );
  modport slave (
    input in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, zero
  );
endinterface

// File: rtl/nibble_subtractor.sv
// nibble_subtractor: combinational 4-bit a - b - bin with borrow-out
module nibble_subtractor
  import subtractor_pkg::*;
(
  input  logic [NIBBLE-1:0] a,
  input  logic [NIBBLE-1:0] b,
  input  logic              bin,
  output logic [NIBBLE-1:0] d,
  output logic              bout
);
  assign {bout, d} = {1'b0, a} - {1'b0, b} - {{NIBBLE{1'b0}}, bin};
endmodule

// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: W-bit a - b - bin, one nibble per clock LSB first, behind valid/ready
module nibble_serial_subtractor
  import subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  nibble_serial_subtractor_if.slave bus
);
  localparam int N = nibble_count(WIDTH);
  localparam int IW = $clog2(N);
  if (WIDTH % NIBBLE != 0 || WIDTH < 8) begin : g_bad_width
    $error("WIDTH must be a multiple of 4 and at least 8");
  end
  state_t state, state_nx;
  logic [WIDTH-1:0] a_q, b_q, diff_q, diff_nx;
  logic [IW-1:0] idx;
  logic [NIBBLE-1:0] d;
  logic borrow, bo, ovf_q, zero_q, last;
  assign last = idx == IW'(N - 1);
  nibble_subtractor u_nib (
    .a(a_q[idx*NIBBLE +: NIBBLE]),
    .b(b_q[idx*NIBBLE +: NIBBLE]),
    .bin(borrow),
    .d(d),
    .bout(bo)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (bus.in_valid ? RUN : IDLE)
             : state == RUN  ? (last ? DONE : RUN)
             : (bus.out_ready ? IDLE : DONE);
  always_comb begin
    bus.in_ready = state == IDLE;
    bus.out_valid = state == DONE;
  end
  // full result with the current nibble merged in, so flags see the final value
  always_comb begin
    diff_nx = diff_q;
    diff_nx[idx*NIBBLE +: NIBBLE] = d;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      diff_q <= '0;
      borrow <= 1'b0;
      idx <= '0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
    end else if (state == IDLE && bus.in_valid) begin
      a_q <= bus.a;
      b_q <= bus.b;
      borrow <= bus.bin;
      idx <= '0;
    end else if (state == RUN) begin
      diff_q <= diff_nx;
      borrow <= bo;
      idx <= idx + 1'b1;
      if (last) begin
        ovf_q <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (diff_nx[WIDTH-1] ^ a_q[WIDTH-1]);
        zero_q <= ~|diff_nx;
      end
    end
  assign bus.diff = diff_q;
  assign bus.bout = borrow;
  assign bus.ovf = ovf_q;
  assign bus.zero = zero_q;
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb_nibble_serial_subtractor: directed checks of the serial subtractor at WIDTH 8 and 16
module tb_nibble_serial_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int fails = 0;
  always #5 clk = ~clk;
  nibble_serial_subtractor_if #(.WIDTH(8)) i8 ();
  nibble_serial_subtractor_if #(.WIDTH(16)) i16 ();
  nibble_serial_subtractor #(.WIDTH(8)) d8 (.clk(clk), .rst(rst), .bus(i8.slave));
  nibble_serial_subtractor #(.WIDTH(16)) d16 (.clk(clk), .rst(rst), .bus(i16.slave));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic accept8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    @(negedge clk);
    check("in_ready_before_accept", 32'(i8.in_ready), 32'd1);
    i8.a = a;
    i8.b = b;
    i8.bin = bin;
    i8.in_valid = 1'b1;
    @(negedge clk);
    i8.in_valid = 1'b0;
    check("out_valid_after_E", 32'(i8.out_valid), 32'd0);
    check("in_ready_after_E", 32'(i8.in_ready), 32'd0);
  endtask
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input logic [7:0] ed, input logic eb, input logic eo, input logic ez);
    accept8(a, b, bin);
    @(negedge clk);
    check({tag, "_valid_E1"}, 32'(i8.out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid_E2"}, 32'(i8.out_valid), 32'd1);
    check({tag, "_diff"}, 32'(i8.diff), 32'(ed));
    check({tag, "_bout"}, 32'(i8.bout), 32'(eb));
    check({tag, "_ovf"}, 32'(i8.ovf), 32'(eo));
    check({tag, "_zero"}, 32'(i8.zero), 32'(ez));
    i8.out_ready = 1'b1;
    @(negedge clk);
    i8.out_ready = 1'b0;
    check({tag, "_valid_after_take"}, 32'(i8.out_valid), 32'd0);
    check({tag, "_ready_after_take"}, 32'(i8.in_ready), 32'd1);
  endtask
  initial begin
    i8.in_valid = 1'b0; i8.a = '0; i8.b = '0; i8.bin = 1'b0; i8.out_ready = 1'b0;
    i16.in_valid = 1'b0; i16.a = '0; i16.b = '0; i16.bin = 1'b0; i16.out_ready = 1'b0;
    #2;
    check("rst_in_ready", 32'(i8.in_ready), 32'd1);
    check("rst_out_valid", 32'(i8.out_valid), 32'd0);
    check("rst_diff", 32'(i8.diff), 32'd0);
    check("rst_flags", {29'd0, i8.bout, i8.ovf, i8.zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    op8("5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, 1'b0);
    op8("10_0f", 8'h10, 8'h0F, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0);
    op8("00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
    op8("80_00_b1", 8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0);
    op8("7f_7f", 8'h7F, 8'h7F, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    // backpressure with a competing in_valid and operand changes while held
    accept8(8'h5A, 8'h3C, 1'b0);
    i8.a = 8'hFF;
    i8.b = 8'h01;
    repeat (2) @(negedge clk);
    check("bp_valid", 32'(i8.out_valid), 32'd1);
    i8.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(i8.out_valid), 32'd1);
      check("bp_hold_ready", 32'(i8.in_ready), 32'd0);
      check("bp_hold_diff", 32'(i8.diff), 32'h1E);
    end
    i8.in_valid = 1'b0;
    i8.out_ready = 1'b1;
    @(negedge clk);
    i8.out_ready = 1'b0;
    check("bp_valid_after_take", 32'(i8.out_valid), 32'd0);
    check("bp_ready_after_take", 32'(i8.in_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("bp_no_second_op", 32'(i8.out_valid), 32'd0);
    check("bp_still_idle", 32'(i8.in_ready), 32'd1);
    // asynchronous reset mid-RUN
    accept8(8'h5A, 8'h3C, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(i8.out_valid), 32'd0);
    check("arst_in_ready", 32'(i8.in_ready), 32'd1);
    check("arst_diff", 32'(i8.diff), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("arst_no_valid", 32'(i8.out_valid), 32'd0);
    op8("33_11", 8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0);
    // WIDTH=16 latency and cross-nibble borrow chain
    @(negedge clk);
    i16.a = 16'h1000;
    i16.b = 16'h0001;
    i16.bin = 1'b0;
    i16.in_valid = 1'b1;
    @(negedge clk);
    i16.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("w16_not_yet_valid", 32'(i16.out_valid), 32'd0);
      @(negedge clk);
    end
    check("w16_valid_E4", 32'(i16.out_valid), 32'd1);
    check("w16_diff", 32'(i16.diff), 32'h0FFF);
    check("w16_bout", 32'(i16.bout), 32'd0);
    check("w16_ovf", 32'(i16.ovf), 32'd0);
    check("w16_zero", 32'(i16.zero), 32'd0);
    i16.out_ready = 1'b1;
    @(negedge clk);
    i16.out_ready = 1'b0;
    check("w16_ready_after_take", 32'(i16.in_ready), 32'd1);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
